// File: rtl/id_ex_stage_reg_pkg.sv
// rtl/id_ex_stage_reg_pkg.sv - shared widths for the ID/EX pipeline register
// Purpose: default bus widths used by id_ex_stage_reg and load_use_detect.
// Ports: none (package).
package id_ex_stage_reg_pkg;

    localparam int unsigned DATA_W_DEF = 64;  // operand / immediate width
    localparam int unsigned ADDR_W_DEF = 64;  // PC width
    localparam int unsigned REG_AW_DEF = 5;   // register index width
    localparam int unsigned CTRL_W_DEF = 32;  // decoded control bundle width
    localparam int unsigned CNT_W_DEF  = 32;  // stall counter width
    localparam int unsigned INST_W     = 32;  // raw instruction width

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// rtl/id_ex_stage_reg_load_use_detect.sv - combinational load-use hazard compare
// Purpose: flags an ID instruction that reads the destination of a load still in EX.
// Ports:
//   id_valid_i              ID holds a valid instruction
//   ex_valid_i              EX entry valid
//   ex_mem_read_i           EX entry is a load
//   ex_rd_we_i              EX entry writes its destination
//   ex_rd_addr_i            EX destination index
//   rs1_addr_i / rs1_re_i   ID source 1 index / used
//   rs2_addr_i / rs2_re_i   ID source 2 index / used
//   hazard_o                load-use hazard this cycle
module load_use_detect
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              id_valid_i,
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_rd_we_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic              rs1_re_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic              rs2_re_i,
    output logic              hazard_o
);

    logic ex_load_live;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    assign ex_load_live = ex_valid_i & ex_mem_read_i & ex_rd_we_i & (ex_rd_addr_i != '0);
    assign rs1_hit      = rs1_re_i & (rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit      = rs2_re_i & (rs2_addr_i == ex_rd_addr_i);
    assign hazard_o     = id_valid_i & ex_load_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use bubble insertion
// Purpose: registers the decoded ID bundle into EX, inserts one bubble per load-use
//   pair, honours EX back-pressure and branch flush, counts inserted bubbles.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   IdValidIn / IdReadyOut             ID handshake (IdReadyOut low holds ID)
//   PcIdIn .. Rs2DataFwdIn             ID instruction fields and forwarded operands
//   ExReadyIn                          EX consumes its entry this cycle
//   FlushIn                            ID instruction is wrong-path
//   ExValidOut .. Rs2DataExOut         registered EX entry
//   LoadUseStallOut                    hazard detected this cycle (combinational)
//   StallCountOut                      saturating count of load-use bubbles
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IdValidIn,
    output logic              IdReadyOut,
    input  logic [ADDR_W-1:0] PcIdIn,
    input  logic [INST_W-1:0] InstIdIn,
    input  logic [CTRL_W-1:0] CtrlIdIn,
    input  logic [DATA_W-1:0] ImmIdIn,
    input  logic              MemReadIdIn,
    input  logic [REG_AW-1:0] RdAddrIdIn,
    input  logic              RdWriteEnableIdIn,
    input  logic [REG_AW-1:0] Rs1AddrIdIn,
    input  logic [REG_AW-1:0] Rs2AddrIdIn,
    input  logic              Rs1ReadEnableIdIn,
    input  logic              Rs2ReadEnableIdIn,
    input  logic [DATA_W-1:0] Rs1DataFwdIn,
    input  logic [DATA_W-1:0] Rs2DataFwdIn,
    input  logic              ExReadyIn,
    input  logic              FlushIn,
    output logic              ExValidOut,
    output logic [ADDR_W-1:0] PcExOut,
    output logic [INST_W-1:0] InstExOut,
    output logic [CTRL_W-1:0] CtrlExOut,
    output logic [DATA_W-1:0] ImmExOut,
    output logic              MemReadExOut,
    output logic [REG_AW-1:0] RdAddrExOut,
    output logic              RdWriteEnableExOut,
    output logic [DATA_W-1:0] Rs1DataExOut,
    output logic [DATA_W-1:0] Rs2DataExOut,
    output logic              LoadUseStallOut,
    output logic [CNT_W-1:0]  StallCountOut
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              mem_read_q, mem_read_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic              rd_we_q, rd_we_d;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic adv;
    logic hazard;

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .id_valid_i    (IdValidIn),
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (mem_read_q),
        .ex_rd_we_i    (rd_we_q),
        .ex_rd_addr_i  (rd_addr_q),
        .rs1_addr_i    (Rs1AddrIdIn),
        .rs1_re_i      (Rs1ReadEnableIdIn),
        .rs2_addr_i    (Rs2AddrIdIn),
        .rs2_re_i      (Rs2ReadEnableIdIn),
        .hazard_o      (hazard)
    );

    // The EX slot may be rewritten when it is empty or being consumed.
    assign adv             = ExReadyIn | ~valid_q;
    // A flush drops ID, so ID is consumed even when a hazard is present.
    assign IdReadyOut      = adv & (FlushIn | ~hazard);
    assign LoadUseStallOut = hazard;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        ctrl_d     = ctrl_q;
        imm_d      = imm_q;
        mem_read_d = mem_read_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = rd_we_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (adv) begin
            if (FlushIn | hazard) begin
                // Bubble: payload keeps its old value, only the control bits clear.
                valid_d    = 1'b0;
                mem_read_d = 1'b0;
                rd_we_d    = 1'b0;
            end else begin
                valid_d    = IdValidIn;
                pc_d       = PcIdIn;
                inst_d     = InstIdIn;
                ctrl_d     = CtrlIdIn;
                imm_d      = ImmIdIn;
                mem_read_d = IdValidIn & MemReadIdIn;
                rd_addr_d  = RdAddrIdIn;
                // Writes to x0 are squashed here so downstream never forwards x0.
                rd_we_d    = IdValidIn & RdWriteEnableIdIn & (RdAddrIdIn != '0);
                rs1_data_d = Rs1DataFwdIn;
                rs2_data_d = Rs2DataFwdIn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            inst_q     <= '0;
            ctrl_q     <= '0;
            imm_q      <= '0;
            mem_read_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            ctrl_q     <= ctrl_d;
            imm_q      <= imm_d;
            mem_read_q <= mem_read_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    // Counts only bubbles caused by a hazard; flush bubbles are not stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (adv & hazard & ~FlushIn & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ExValidOut         = valid_q;
    assign PcExOut            = pc_q;
    assign InstExOut          = inst_q;
    assign CtrlExOut          = ctrl_q;
    assign ImmExOut           = imm_q;
    assign MemReadExOut       = mem_read_q;
    assign RdAddrExOut        = rd_addr_q;
    assign RdWriteEnableExOut = rd_we_q;
    assign Rs1DataExOut       = rs1_data_q;
    assign Rs2DataExOut       = rs2_data_q;
    assign StallCountOut      = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        IdValidIn, IdReadyOut;
    logic [63:0] PcIdIn;
    logic [31:0] InstIdIn, CtrlIdIn;
    logic [63:0] ImmIdIn;
    logic        MemReadIdIn;
    logic [4:0]  RdAddrIdIn, Rs1AddrIdIn, Rs2AddrIdIn;
    logic        RdWriteEnableIdIn, Rs1ReadEnableIdIn, Rs2ReadEnableIdIn;
    logic [63:0] Rs1DataFwdIn, Rs2DataFwdIn;
    logic        ExReadyIn, FlushIn;
    logic        ExValidOut;
    logic [63:0] PcExOut;
    logic [31:0] InstExOut, CtrlExOut;
    logic [63:0] ImmExOut;
    logic        MemReadExOut;
    logic [4:0]  RdAddrExOut;
    logic        RdWriteEnableExOut;
    logic [63:0] Rs1DataExOut, Rs2DataExOut;
    logic        LoadUseStallOut;
    logic [31:0] StallCountOut;

    id_ex_stage_reg #(
        .DATA_W(64), .ADDR_W(64), .REG_AW(5), .CTRL_W(32), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .IdValidIn(IdValidIn), .IdReadyOut(IdReadyOut),
        .PcIdIn(PcIdIn), .InstIdIn(InstIdIn), .CtrlIdIn(CtrlIdIn), .ImmIdIn(ImmIdIn),
        .MemReadIdIn(MemReadIdIn), .RdAddrIdIn(RdAddrIdIn),
        .RdWriteEnableIdIn(RdWriteEnableIdIn),
        .Rs1AddrIdIn(Rs1AddrIdIn), .Rs2AddrIdIn(Rs2AddrIdIn),
        .Rs1ReadEnableIdIn(Rs1ReadEnableIdIn), .Rs2ReadEnableIdIn(Rs2ReadEnableIdIn),
        .Rs1DataFwdIn(Rs1DataFwdIn), .Rs2DataFwdIn(Rs2DataFwdIn),
        .ExReadyIn(ExReadyIn), .FlushIn(FlushIn),
        .ExValidOut(ExValidOut), .PcExOut(PcExOut), .InstExOut(InstExOut),
        .CtrlExOut(CtrlExOut), .ImmExOut(ImmExOut), .MemReadExOut(MemReadExOut),
        .RdAddrExOut(RdAddrExOut), .RdWriteEnableExOut(RdWriteEnableExOut),
        .Rs1DataExOut(Rs1DataExOut), .Rs2DataExOut(Rs2DataExOut),
        .LoadUseStallOut(LoadUseStallOut), .StallCountOut(StallCountOut)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model of the EX entry: what the slot should hold after each edge.
    bit          m_known = 0;
    bit          m_valid, m_mr, m_we;
    logic [63:0] m_pc, m_imm, m_rs1, m_rs2;
    logic [31:0] m_inst, m_ctrl;
    logic [4:0]  m_rd;
    longint unsigned m_cnt;
    localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

    function automatic bit model_hazard();
        bit reads_it;
        reads_it = (Rs1ReadEnableIdIn && Rs1AddrIdIn == m_rd) ||
                   (Rs2ReadEnableIdIn && Rs2AddrIdIn == m_rd);
        return IdValidIn && m_valid && m_mr && m_we && (m_rd != 0) && reads_it;
    endfunction

    task automatic model_edge();
        bit can_move, haz;
        can_move = ExReadyIn || !m_valid;
        haz      = model_hazard();
        if (rst) begin
            m_valid = 0; m_mr = 0; m_we = 0; m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0;
            m_inst = 0; m_ctrl = 0; m_rd = 0; m_cnt = 0; m_known = 1;
        end else if (can_move) begin
            if (FlushIn || haz) begin
                m_valid = 0; m_mr = 0; m_we = 0;
                if (!FlushIn) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            end else begin
                m_valid = IdValidIn;
                m_pc = PcIdIn; m_inst = InstIdIn; m_ctrl = CtrlIdIn; m_imm = ImmIdIn;
                m_rd = RdAddrIdIn; m_rs1 = Rs1DataFwdIn; m_rs2 = Rs2DataFwdIn;
                m_mr = IdValidIn && MemReadIdIn;
                m_we = IdValidIn && RdWriteEnableIdIn && (RdAddrIdIn != 0);
            end
        end
    endtask

    // One clock: combinational checks, edge, model update, registered checks.
    task automatic cycle();
        bit can_move, haz;
        if (m_known) begin
            can_move = ExReadyIn || !m_valid;
            haz      = model_hazard();
            chk("id_ready", IdReadyOut, can_move && (FlushIn || !haz));
            chk("load_use_stall", LoadUseStallOut, haz);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (m_known) begin
            chk("ex_valid", ExValidOut, m_valid);
            chk("pc", PcExOut, m_pc);
            chk("inst", InstExOut, m_inst);
            chk("ctrl", CtrlExOut, m_ctrl);
            chk("imm", ImmExOut, m_imm);
            chk("mem_read", MemReadExOut, m_mr);
            chk("rd_addr", RdAddrExOut, m_rd);
            chk("rd_we", RdWriteEnableExOut, m_we);
            chk("rs1_data", Rs1DataExOut, m_rs1);
            chk("rs2_data", Rs2DataExOut, m_rs2);
            chk("stall_count", StallCountOut, m_cnt);
        end
    endtask

    task automatic drive(input bit v, input bit mr, input int rd, input bit we,
                         input int r1, input bit e1, input int r2, input bit e2,
                         input bit rdy, input bit fl);
        IdValidIn = v; MemReadIdIn = mr; RdAddrIdIn = 5'(rd); RdWriteEnableIdIn = we;
        Rs1AddrIdIn = 5'(r1); Rs1ReadEnableIdIn = e1;
        Rs2AddrIdIn = 5'(r2); Rs2ReadEnableIdIn = e2;
        ExReadyIn = rdy; FlushIn = fl;
        PcIdIn = {$urandom, $urandom}; InstIdIn = $urandom; CtrlIdIn = $urandom;
        ImmIdIn = {$urandom, $urandom};
        Rs1DataFwdIn = {$urandom, $urandom}; Rs2DataFwdIn = {$urandom, $urandom};
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        cycle(); cycle();
        chk("reset_valid", ExValidOut, 1'b0);
        chk("reset_count", StallCountOut, 32'd0);
        rst = 1'b0;

        // ld x5 ; add x6,x5,x7 back-to-back
        drive(1, 1, 5, 1, 1, 1, 0, 0, 1, 0);
        cycle();
        chk("ld_x5_in_ex", ExValidOut, 1'b1);
        drive(1, 0, 6, 1, 5, 1, 7, 1, 1, 0);
        chk("ldx5_hazard", LoadUseStallOut, 1'b1);
        chk("ldx5_id_hold", IdReadyOut, 1'b0);
        cycle();
        chk("ldx5_bubble", ExValidOut, 1'b0);
        chk("ldx5_count", StallCountOut, 32'd1);
        chk("ldx5_hazard_gone", LoadUseStallOut, 1'b0);
        chk("ldx5_id_go", IdReadyOut, 1'b1);
        cycle();
        chk("add_in_ex", RdAddrExOut, 5'd6);

        // ld x0 ; add x6,x0,x0 : no hazard
        drive(1, 1, 0, 1, 2, 1, 0, 0, 1, 0);
        cycle();
        chk("ldx0_we", RdWriteEnableExOut, 1'b0);
        drive(1, 0, 6, 1, 0, 1, 0, 1, 1, 0);
        chk("ldx0_no_hazard", LoadUseStallOut, 1'b0);
        chk("ldx0_id_ready", IdReadyOut, 1'b1);
        cycle();
        chk("ldx0_no_bubble", ExValidOut, 1'b1);
        chk("ldx0_count", StallCountOut, 32'd1);

        // EX back-pressure for three cycles
        drive(1, 0, 8, 1, 1, 1, 2, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_id_hold", IdReadyOut, 1'b0);
            cycle();
            chk("bp_held_rd", RdAddrExOut, 5'd6);
        end
        ExReadyIn = 1'b1; #1;
        cycle();
        chk("bp_resume_rd", RdAddrExOut, 5'd8);

        // flush coincident with a load-use hazard
        drive(1, 1, 9, 1, 0, 0, 0, 0, 1, 0);
        cycle();
        drive(1, 0, 10, 1, 9, 1, 0, 0, 1, 1);
        chk("flush_hazard", LoadUseStallOut, 1'b1);
        chk("flush_id_ready", IdReadyOut, 1'b1);
        cycle();
        chk("flush_bubble", ExValidOut, 1'b0);
        chk("flush_count", StallCountOut, 32'd1);

        // reset with a valid entry in EX
        drive(1, 0, 11, 1, 0, 0, 0, 0, 1, 0);
        cycle();
        chk("pre_reset_valid", ExValidOut, 1'b1);
        rst = 1'b1; #1;
        cycle();
        rst = 1'b0;
        chk("midreset_valid", ExValidOut, 1'b0);
        chk("midreset_count", StallCountOut, 32'd0);

        // counter saturation
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_cnt = CNT_MAX;
        chk("sat_preload", StallCountOut, 32'hFFFF_FFFF);
        drive(1, 1, 3, 1, 0, 0, 0, 0, 1, 0);
        cycle();
        drive(1, 0, 4, 1, 0, 0, 3, 1, 1, 0);
        chk("sat_hazard", LoadUseStallOut, 1'b1);
        cycle();
        chk("sat_bubble", ExValidOut, 1'b0);
        chk("sat_count", StallCountOut, 32'hFFFF_FFFF);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit rdy;
            rdy = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), rdy,
                  rdy && ($urandom_range(0, 9) == 0));
            rst = ($urandom_range(0, 199) == 0);
            #1;
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
